// File: rtl/bitdemux_deser.sv
// bitdemux_deser: serial-to-parallel collector.
// This block is the write-side counterpart of bitmux. It places a stream of
// single bits into successive index positions of an N-bit word. Once all N
// positions are filled, it presents the complete word.
//
// Parameters
//   N          word width in bits (N >= 2)
//   MSB_FIRST  0: first bit lands in word[0]; 1: first bit lands in word[N-1]
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over clr)
//   clr        synchronous abort; discards a partial or held word
//   in_valid   in_bit is valid this cycle
//   in_ready   block accepts in_bit this cycle
//   in_bit     serial data bit
//   out_valid  out_word holds a complete word
//   out_ready  consumer takes out_word this cycle
//   out_word   assembled word
//   fill_cnt   bits accepted into the current word (0 while holding)
module bitdemux_deser #(
    parameter int N         = 3,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_word,
    output logic [CW-1:0] fill_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [N-1:0]  r_word;
    logic [N-1:0]  w_word_nxt;
    logic          w_accept;
    logic          w_consume;

    // Index into the word for the bit arriving when cnt bits are already in.
    function automatic logic [CW-1:0] f_pos(input logic [CW-1:0] cnt);
        if (MSB_FIRST)
            return CW'(N - 1) - cnt;
        else
            return cnt;
    endfunction

    // out_valid is simply the registered HOLD state.
    assign out_valid = (r_state == HOLD);
    assign in_ready  = (r_state == FILL) | ((r_state == HOLD) & out_ready);
    assign out_word  = r_word;
    assign fill_cnt  = r_cnt;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        if (clr) begin
            // A bit offered alongside clr is dropped even if in_ready reads 1.
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
            w_word_nxt  = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        w_word_nxt[f_pos(r_cnt)] = in_bit;
                        if (r_cnt == CW'(N - 1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = HOLD;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (w_consume) begin
                        w_state_nxt = FILL;
                        // Back-to-back: the next word starts with a cleared
                        // word so no bit of the previous one leaks through.
                        if (w_accept) begin
                            w_word_nxt                 = '0;
                            w_word_nxt[f_pos(CW'(0))]  = in_bit;
                            w_cnt_nxt                  = CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = '0;
                    w_word_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
        end
    end

endmodule
